cfg_bus_arb: RTL and testbench

- Arbitrates the shared configuration-register bus (reg_ce/reg_addr/reg_we/reg_wdata/reg_rdata) into cfg_digiblk between two requesters.
- Requester 0 is the serial-interface front end (I2C/SPI). Requester 1 is an on-chip sequencer, for example a test/boot loader writing cfg_* registers.
- Round-robin arbitration, one transaction in flight, fixed read latency, single-cycle ack pulse per requester.
- Sits between chip_itf_top/sequencer and cfg_digiblk inside the chip top.

---
 rtl/cfg_bus_pkg.sv | 17 +
 rtl/cfg_bus_rr2.sv | 33 +++
 rtl/cfg_bus_arb.sv | 148 ++++++++++++++
 tb/tb_cfg_bus_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the configuration-bus arbiter: FSM encoding, default widths, error data.
// No logic; imported by cfg_bus_rr2 and cfg_bus_arb.
package cfg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic [15:0] ERR_DAT = 16'hDEAD;

endpackage

// File: rtl/cfg_bus_rr2.sv
// 2-way round-robin grant picker: combinational grant, registered last_grant (resets to 1 so req 0 wins first tie).
// Zero-cycle grant; last_grant only moves when upd is high and something is granted.
module cfg_bus_rr2
  import cfg_bus_pkg::*;
(
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (upd && (|gnt)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/cfg_bus_arb.sv
// Two-requester round-robin arbiter onto the cfg register bus; write ack at +2, read ack at +2+RD_LAT.
// One transaction in flight; req is sampled only in IDLE. Optional address range check: CFG_BUS_ARB_RANGE_CHK_EN.
module cfg_bus_arb
  import cfg_bus_pkg::*;
#(
  parameter int             AW       = AW_DEF,
  parameter int             DW       = DW_DEF,
  parameter int             RD_LAT   = 1,
  parameter logic [AW-1:0]  MAX_ADDR = '1
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          reg_ce,
  output logic [AW-1:0] reg_addr,
  output logic          reg_we,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata,
  output logic          busy,
  output logic          err
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t     state;
  logic [2:0] cnt;
  logic       gsel;
  logic [1:0] gnt;
  logic       oor;
  req_t       m0_bus, m1_bus, gnt_bus;

  assign m0_bus  = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus  = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
  assign gnt_bus = gnt[1] ? m1_bus : m0_bus;
  assign busy    = (state != IDLE);

  cfg_bus_rr2 u_rr2 (
    .CLK   (CLK),
    .rst_n (rst_n),
    .req   ({m1_req, m0_req}),
    .upd   (state == IDLE),
    .gnt   (gnt)
  );

`ifdef CFG_BUS_ARB_RANGE_CHK_EN
  assign oor = (gnt_bus.addr > MAX_ADDR);
`else
  logic unused_max_addr;
  assign unused_max_addr = ^MAX_ADDR;
  assign oor = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gsel      <= 1'b0;
      reg_ce    <= 1'b0;
      reg_addr  <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      reg_ce <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            gsel <= gnt[1];
            if (oor) begin
              // Rejected address: answer straight away without touching the bus.
              state <= DONE;
              err   <= 1'b1;
              if (gnt[1]) begin
                m1_ack   <= 1'b1;
                m1_rdata <= DW'(ERR_DAT);
              end else begin
                m0_ack   <= 1'b1;
                m0_rdata <= DW'(ERR_DAT);
              end
            end else begin
              state     <= ISSUE;
              reg_ce    <= 1'b1;
              reg_addr  <= gnt_bus.addr;
              reg_we    <= gnt_bus.we;
              reg_wdata <= gnt_bus.wdata;
            end
          end
        end
        ISSUE: begin
          if (reg_we) begin
            state <= DONE;
            if (gsel) begin
              m1_ack   <= 1'b1;
              m1_rdata <= '0;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= '0;
            end
          end else begin
            state <= WAIT;
            cnt   <= 3'(RD_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= DONE;
            if (gsel) begin
              m1_ack   <= 1'b1;
              m1_rdata <= reg_rdata;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= reg_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bus_arb.sv
// Directed bench for cfg_bus_arb: instance a uses RD_LAT=1, instance b uses RD_LAT=3, both MAX_ADDR=8'h3F.
module tb_cfg_bus_arb;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic        a_m0_req, a_m0_we, a_m0_ack, a_m1_req, a_m1_we, a_m1_ack;
  logic [7:0]  a_m0_addr, a_m1_addr, a_reg_addr;
  logic [15:0] a_m0_wdata, a_m0_rdata, a_m1_wdata, a_m1_rdata, a_reg_wdata, a_reg_rdata;
  logic        a_reg_ce, a_reg_we, a_busy, a_err;

  logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack;
  logic [7:0]  b_m0_addr, b_m1_addr, b_reg_addr;
  logic [15:0] b_m0_wdata, b_m0_rdata, b_m1_wdata, b_m1_rdata, b_reg_wdata, b_reg_rdata;
  logic        b_reg_ce, b_reg_we, b_busy, b_err;

  logic [15:0] a_mem [256];
  logic [15:0] b_mem [256];

  cfg_bus_arb #(.AW(8), .DW(16), .RD_LAT(1), .MAX_ADDR(8'h3F)) u_a (
    .CLK(CLK), .rst_n(rst_n),
    .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_we(a_m0_we), .m0_wdata(a_m0_wdata),
    .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_we(a_m1_we), .m1_wdata(a_m1_wdata),
    .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .reg_ce(a_reg_ce), .reg_addr(a_reg_addr), .reg_we(a_reg_we), .reg_wdata(a_reg_wdata),
    .reg_rdata(a_reg_rdata), .busy(a_busy), .err(a_err)
  );

  cfg_bus_arb #(.AW(8), .DW(16), .RD_LAT(3), .MAX_ADDR(8'h3F)) u_b (
    .CLK(CLK), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_we(b_m0_we), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_we(b_m1_we), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .reg_ce(b_reg_ce), .reg_addr(b_reg_addr), .reg_we(b_reg_we), .reg_wdata(b_reg_wdata),
    .reg_rdata(b_reg_rdata), .busy(b_busy), .err(b_err)
  );

  function automatic logic [15:0] mem_init(input int i);
    return (i == 8'h22) ? 16'hA5A5 : 16'(16'h1000 + i);
  endfunction

  // Register-file model: read data appears the cycle after reg_ce and is held.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      a_reg_rdata <= '0;
      b_reg_rdata <= '0;
      for (int i = 0; i < 256; i++) begin
        a_mem[i] <= mem_init(i);
        b_mem[i] <= mem_init(i);
      end
    end else begin
      if (a_reg_ce) begin
        if (a_reg_we) a_mem[a_reg_addr] <= a_reg_wdata;
        else          a_reg_rdata <= a_mem[a_reg_addr];
      end
      if (b_reg_ce) begin
        if (b_reg_we) b_mem[b_reg_addr] <= b_reg_wdata;
        else          b_reg_rdata <= b_mem[b_reg_addr];
      end
    end
  end

`ifdef CFG_BUS_ARB_RANGE_CHK_EN
  localparam int          OOR_CE    = 0;
  localparam int          OOR_ACK   = 1;
  localparam logic [15:0] OOR_RDATA = 16'hDEAD;
  localparam int          OOR_ERR   = 1;
`else
  localparam int          OOR_CE    = 1;
  localparam int          OOR_ACK   = 3;
  localparam logic [15:0] OOR_RDATA = 16'h1040;
  localparam int          OOR_ERR   = 0;
`endif

  task automatic test_reset();
    @(posedge CLK); #1;
    total++;
    if ({a_reg_ce, a_reg_addr, a_reg_we, a_reg_wdata, a_m0_ack, a_m1_ack,
         a_m0_rdata, a_m1_rdata, a_busy, a_err} !== '0) begin
      bad++;
      $display("FAIL reset_a: outputs not all zero (ce=%0b ack=%0b%0b busy=%0b)",
               a_reg_ce, a_m1_ack, a_m0_ack, a_busy);
    end
    total++;
    if ({b_reg_ce, b_reg_addr, b_reg_we, b_reg_wdata, b_m0_ack, b_m1_ack,
         b_m0_rdata, b_m1_rdata, b_busy, b_err} !== '0) begin
      bad++;
      $display("FAIL reset_b: outputs not all zero (ce=%0b ack=%0b%0b busy=%0b)",
               b_reg_ce, b_m1_ack, b_m0_ack, b_busy);
    end
  endtask

  task automatic test_write();
    int ce_cyc = -1, ack_cyc = -1, m0_acks = 0, m1_acks = 0;
    logic [7:0]  ce_addr = '0;
    logic        ce_we = 1'b0;
    logic [15:0] ce_wdata = '0, ack_rdata = 16'hFFFF;
    logic        busy1 = 1'b0;
    @(posedge CLK); #1;
    a_m0_we = 1'b1; a_m0_addr = 8'h10; a_m0_wdata = 16'h1234; a_m0_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (c == 1) busy1 = a_busy;
      if (a_reg_ce && ce_cyc < 0) begin
        ce_cyc = c; ce_addr = a_reg_addr; ce_we = a_reg_we; ce_wdata = a_reg_wdata;
      end
      if (a_m0_ack) begin
        m0_acks++;
        if (ack_cyc < 0) begin ack_cyc = c; ack_rdata = a_m0_rdata; end
        a_m0_req = 1'b0;
      end
      if (a_m1_ack) m1_acks++;
    end
    total++; if (ce_cyc !== 1) begin bad++; $display("FAIL wr_ce_cycle: got %0d want 1", ce_cyc); end
    total++; if (ce_addr !== 8'h10) begin bad++; $display("FAIL wr_addr: got %0h want 10", ce_addr); end
    total++; if (ce_we !== 1'b1) begin bad++; $display("FAIL wr_we: got %0b want 1", ce_we); end
    total++; if (ce_wdata !== 16'h1234) begin bad++; $display("FAIL wr_wdata: got %0h want 1234", ce_wdata); end
    total++; if (ack_cyc !== 2) begin bad++; $display("FAIL wr_ack_cycle: got %0d want 2", ack_cyc); end
    total++; if (ack_rdata !== 16'h0) begin bad++; $display("FAIL wr_rdata: got %0h want 0", ack_rdata); end
    total++; if (m0_acks !== 1) begin bad++; $display("FAIL wr_m0_ack_count: got %0d want 1", m0_acks); end
    total++; if (m1_acks !== 0) begin bad++; $display("FAIL wr_m1_ack_count: got %0d want 0", m1_acks); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL wr_busy: got %0b want 1", busy1); end
    total++; if (a_mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL wr_mem: got %0h want 1234", a_mem[8'h10]); end
  endtask

  task automatic test_read_latency();
    int a_ack = -1, b_ack = -1, a_n = 0, b_n = 0;
    logic [15:0] a_rd = '0, b_rd = '0;
    @(posedge CLK); #1;
    a_m1_we = 1'b0; a_m1_addr = 8'h22; a_m1_req = 1'b1;
    b_m1_we = 1'b0; b_m1_addr = 8'h22; b_m1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (a_m1_ack) begin a_n++; if (a_ack < 0) begin a_ack = c; a_rd = a_m1_rdata; end a_m1_req = 1'b0; end
      if (b_m1_ack) begin b_n++; if (b_ack < 0) begin b_ack = c; b_rd = b_m1_rdata; end b_m1_req = 1'b0; end
    end
    total++; if (a_ack !== 3) begin bad++; $display("FAIL rd1_ack_cycle: got %0d want 3", a_ack); end
    total++; if (a_rd !== 16'hA5A5) begin bad++; $display("FAIL rd1_rdata: got %0h want a5a5", a_rd); end
    total++; if (b_ack !== 5) begin bad++; $display("FAIL rd3_ack_cycle: got %0d want 5", b_ack); end
    total++; if (b_rd !== 16'hA5A5) begin bad++; $display("FAIL rd3_rdata: got %0h want a5a5", b_rd); end
    total++; if (a_n + b_n !== 2) begin bad++; $display("FAIL rd_ack_count: got %0d want 2", a_n + b_n); end
    total++; if (a_m1_rdata !== 16'hA5A5) begin bad++; $display("FAIL rd_hold: got %0h want a5a5", a_m1_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [8] = '{8'h00, 8'h20, 8'h01, 8'h21, 8'h02, 8'h22, 8'h03, 8'h23};
    logic [7:0] seen [$];
    int n0 = 0, n1 = 0, same = 0;
    @(posedge CLK); #1;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge CLK); #1;
    a_m0_we = 1'b1; a_m0_addr = 8'h00; a_m0_wdata = 16'hB000; a_m0_req = 1'b1;
    a_m1_we = 1'b1; a_m1_addr = 8'h20; a_m1_wdata = 16'hB020; a_m1_req = 1'b1;
    for (int c = 1; c <= 60 && (n0 < 4 || n1 < 4); c++) begin
      @(posedge CLK); #1;
      if (a_reg_ce) seen.push_back(a_reg_addr);
      if (a_m0_ack) begin
        n0++;
        if (n0 < 4) begin a_m0_addr = 8'(n0); a_m0_wdata = 16'hB000 + 16'(n0); end
        else a_m0_req = 1'b0;
      end
      if (a_m1_ack) begin
        n1++;
        if (n1 < 4) begin a_m1_addr = 8'h20 + 8'(n1); a_m1_wdata = 16'hB020 + 16'(n1); end
        else a_m1_req = 1'b0;
      end
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    total++; if (n0 !== 4) begin bad++; $display("FAIL b2b_m0_acks: got %0d want 4", n0); end
    total++; if (n1 !== 4) begin bad++; $display("FAIL b2b_m1_acks: got %0d want 4", n1); end
    total++; if (seen.size() !== 8) begin bad++; $display("FAIL b2b_ce_count: got %0d want 8", seen.size()); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      total++;
      if (seen[i] !== exp_seq[i]) begin
        bad++; $display("FAIL b2b_order[%0d]: got %0h want %0h", i, seen[i], exp_seq[i]);
      end
    end
    for (int i = 1; i < seen.size(); i++) if (seen[i][5] == seen[i-1][5]) same++;
    total++; if (same !== 0) begin bad++; $display("FAIL b2b_repeat_grant: got %0d want 0", same); end
    total++; if (a_mem[8'h23] !== 16'hB023) begin bad++; $display("FAIL b2b_mem: got %0h want b023", a_mem[8'h23]); end
  endtask

  task automatic test_reset_mid();
    int acks = 0, ces = 0, busys = 0;
    logic pre_busy;
    logic [7:0] pre_addr;
    @(posedge CLK); #1;
    b_m0_we = 1'b0; b_m0_addr = 8'h05; b_m0_req = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    pre_busy = b_busy; pre_addr = b_reg_addr;
    rst_n = 1'b0; b_m0_req = 1'b0;
    #1;
    total++; if (pre_busy !== 1'b1 || pre_addr !== 8'h05) begin
      bad++; $display("FAIL rst_pre: got busy=%0b addr=%0h want busy=1 addr=05", pre_busy, pre_addr);
    end
    total++;
    if ({b_reg_ce, b_reg_addr, b_reg_we, b_reg_wdata, b_m0_ack, b_m1_ack,
         b_m0_rdata, b_m1_rdata, b_busy, b_err} !== '0) begin
      bad++; $display("FAIL rst_mid: outputs not zero (addr=%0h m1_rdata=%0h busy=%0b), want all 0",
                      b_reg_addr, b_m1_rdata, b_busy);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (b_m0_ack || b_m1_ack) acks++;
      if (b_reg_ce) ces++;
      if (b_busy) busys++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL rst_spurious_ack: got %0d want 0", acks); end
    total++; if (ces + busys !== 0) begin bad++; $display("FAIL rst_idle: got ce=%0d busy=%0d want 0", ces, busys); end
  endtask

  task automatic test_range();
    int ce_n = 0, ack_cyc = -1, err_n = 0;
    logic [15:0] rd = '0;
    @(posedge CLK); #1;
    a_m0_we = 1'b0; a_m0_addr = 8'h40; a_m0_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (a_reg_ce) ce_n++;
      if (a_err) err_n++;
      if (a_m0_ack) begin if (ack_cyc < 0) begin ack_cyc = c; rd = a_m0_rdata; end a_m0_req = 1'b0; end
    end
    total++; if (ce_n !== OOR_CE) begin bad++; $display("FAIL oor_ce: got %0d want %0d", ce_n, OOR_CE); end
    total++; if (ack_cyc !== OOR_ACK) begin bad++; $display("FAIL oor_ack_cycle: got %0d want %0d", ack_cyc, OOR_ACK); end
    total++; if (rd !== OOR_RDATA) begin bad++; $display("FAIL oor_rdata: got %0h want %0h", rd, OOR_RDATA); end
    total++; if (err_n !== OOR_ERR) begin bad++; $display("FAIL oor_err: got %0d want %0d", err_n, OOR_ERR); end
    ce_n = 0; ack_cyc = -1; err_n = 0; rd = '0;
    @(posedge CLK); #1;
    a_m0_addr = 8'h3F; a_m0_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (a_reg_ce) ce_n++;
      if (a_err) err_n++;
      if (a_m0_ack) begin if (ack_cyc < 0) begin ack_cyc = c; rd = a_m0_rdata; end a_m0_req = 1'b0; end
    end
    total++; if (ce_n !== 1 || err_n !== 0) begin bad++; $display("FAIL edge_ce_err: got ce=%0d err=%0d want 1/0", ce_n, err_n); end
    total++; if (ack_cyc !== 3) begin bad++; $display("FAIL edge_ack_cycle: got %0d want 3", ack_cyc); end
    total++; if (rd !== 16'h103F) begin bad++; $display("FAIL edge_rdata: got %0h want 103f", rd); end
  endtask

  task automatic test_req_held();
    int ce_n = 0, acks = 0, ce2 = -1, drop_at = -1;
    @(posedge CLK); #1;
    a_m0_we = 1'b1; a_m0_addr = 8'h30; a_m0_wdata = 16'h5555; a_m0_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge CLK); #1;
      if (c == drop_at) a_m0_req = 1'b0;
      if (a_reg_ce && a_reg_addr == 8'h30) begin ce_n++; if (ce_n == 2) ce2 = c; end
      if (a_m0_ack) begin
        acks++;
        if (acks == 1) drop_at = c + 2;
        else a_m0_req = 1'b0;
      end
    end
    a_m0_req = 1'b0;
    total++; if (ce_n !== 2) begin bad++; $display("FAIL held_ce_count: got %0d want 2", ce_n); end
    total++; if (ce2 !== 4) begin bad++; $display("FAIL held_ce2_cycle: got %0d want 4", ce2); end
    total++; if (acks !== 2) begin bad++; $display("FAIL held_ack_count: got %0d want 2", acks); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = '0; a_m0_wdata = '0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = '0; a_m1_wdata = '0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wdata = '0;
    #23 rst_n = 1'b1;
    test_reset();
    test_write();
    repeat (2) @(posedge CLK);
    test_read_latency();
    repeat (2) @(posedge CLK);
    test_back_to_back();
    repeat (2) @(posedge CLK);
    test_reset_mid();
    test_range();
    repeat (2) @(posedge CLK);
    test_req_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
